// File: rtl/alu_pkg.sv
// Shared ALU definitions: default widths, opcode constants and the buffered result entry layout.
// The parity field exists only when ALU_RESULT_PARITY_EN is defined.
package alu_pkg;

  localparam int ALU_WIDTH = 8;
  localparam int ALU_SEL_W = 4;

  localparam logic [ALU_SEL_W-1:0] ALU_ADD  = 4'h0;
  localparam logic [ALU_SEL_W-1:0] ALU_SUB  = 4'h1;
  localparam logic [ALU_SEL_W-1:0] ALU_MUL  = 4'h2;
  localparam logic [ALU_SEL_W-1:0] ALU_DIV  = 4'h3;
  localparam logic [ALU_SEL_W-1:0] ALU_SHL  = 4'h4;
  localparam logic [ALU_SEL_W-1:0] ALU_SHR  = 4'h5;
  localparam logic [ALU_SEL_W-1:0] ALU_ROL  = 4'h6;
  localparam logic [ALU_SEL_W-1:0] ALU_ROR  = 4'h7;
  localparam logic [ALU_SEL_W-1:0] ALU_AND  = 4'h8;
  localparam logic [ALU_SEL_W-1:0] ALU_OR   = 4'h9;
  localparam logic [ALU_SEL_W-1:0] ALU_XOR  = 4'hA;
  localparam logic [ALU_SEL_W-1:0] ALU_NOR  = 4'hB;
  localparam logic [ALU_SEL_W-1:0] ALU_NAND = 4'hC;
  localparam logic [ALU_SEL_W-1:0] ALU_XNOR = 4'hD;
  localparam logic [ALU_SEL_W-1:0] ALU_GT   = 4'hE;
  localparam logic [ALU_SEL_W-1:0] ALU_EQ   = 4'hF;

  typedef struct packed {
    logic [ALU_WIDTH-1:0] result;
    logic                 carry;
    logic                 zero;
    logic                 neg;
    logic [ALU_SEL_W-1:0] sel;
`ifdef ALU_RESULT_PARITY_EN
    logic                 parity;
`endif
  } alu_entry_t;

endpackage

// File: rtl/alu_fifo_core.sv
// Generic first-word-fall-through FIFO: storage, wrapping pointers and a separate occupancy count.
// Push when full and pop when empty are ignored, so pointers never corrupt.
module alu_fifo_core #(
  parameter int DEPTH   = 4,
  parameter int ENTRY_W = 16,
  parameter int CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic               pop,
  input  logic [ENTRY_W-1:0] wr_data,
  output logic [ENTRY_W-1:0] rd_data,
  output logic [CNT_W-1:0]   count,
  output logic               full,
  output logic               empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [ENTRY_W-1:0] mem [DEPTH];
  logic               do_push;
  logic               do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  // DEPTH is a power of two, so plain pointer overflow is the modulo wrap
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/alu_result_buffer.sv
// Captures ALU results with derived zero/negative flags into a FWFT FIFO with a saturating drop counter.
// Define ALU_RESULT_PARITY_EN to add the stored out_parity output.
module alu_result_buffer
  import alu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = ALU_WIDTH,
  parameter int SEL_W = ALU_SEL_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WIDTH-1:0]           alu_out,
  input  logic                       carry_out,
  input  logic [SEL_W-1:0]           alu_sel,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_result,
  output logic                       out_carry,
  output logic                       out_zero,
  output logic                       out_neg,
  output logic [SEL_W-1:0]           out_sel,
`ifdef ALU_RESULT_PARITY_EN
  output logic                       out_parity,
`endif
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty,
  output logic [7:0]                 drop_count
);

`ifdef ALU_RESULT_PARITY_EN
  localparam int PAR_W = 1;
`else
  localparam int PAR_W = 0;
`endif
  localparam int ENTRY_W = WIDTH + 3 + SEL_W + PAR_W;
  localparam int CNT_W   = $clog2(DEPTH + 1);

  logic [ENTRY_W-1:0] wr_entry;
  logic [ENTRY_W-1:0] head;
  logic               push;
  logic               pop;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign in_ready  = !full;
  assign out_valid = !empty;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

`ifdef ALU_RESULT_PARITY_EN
  assign wr_entry = {alu_out, carry_out, (alu_out == '0), alu_out[WIDTH-1], alu_sel, ^alu_out};
`else
  assign wr_entry = {alu_out, carry_out, (alu_out == '0), alu_out[WIDTH-1], alu_sel};
`endif

  alu_fifo_core #(
    .DEPTH   (DEPTH),
    .ENTRY_W (ENTRY_W),
    .CNT_W   (CNT_W)
  ) u_core (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .pop     (pop),
    .wr_data (wr_entry),
    .rd_data (head),
    .count   (count),
    .full    (full),
    .empty   (empty)
  );

  // Storage is never reset, so the head fields are masked until an entry exists
  assign out_result = empty ? '0 : head[ENTRY_W-1 -: WIDTH];
  assign out_carry  = !empty && head[ENTRY_W-WIDTH-1];
  assign out_zero   = !empty && head[ENTRY_W-WIDTH-2];
  assign out_neg    = !empty && head[ENTRY_W-WIDTH-3];
  assign out_sel    = empty ? '0 : head[PAR_W +: SEL_W];
`ifdef ALU_RESULT_PARITY_EN
  assign out_parity = !empty && head[0];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_count <= '0;
    end else if (in_valid && full) begin
      drop_count <= sat_inc(drop_count);
    end
  end

endmodule

// File: tb/tb_alu_result_buffer.sv
// Scoreboard bench for alu_result_buffer (DEPTH=4): directed scenarios plus randomized traffic.
module tb_alu_result_buffer;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] alu_out;
  logic       carry_out;
  logic [3:0] alu_sel;
  logic       in_valid;
  logic       in_ready;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_result;
  logic       out_carry;
  logic       out_zero;
  logic       out_neg;
  logic [3:0] out_sel;
`ifdef ALU_RESULT_PARITY_EN
  logic       out_parity;
`endif
  logic [2:0] count;
  logic       full;
  logic       empty;
  logic [7:0] drop_count;

  alu_result_buffer #(.DEPTH(DEPTH), .WIDTH(8), .SEL_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .alu_out    (alu_out),
    .carry_out  (carry_out),
    .alu_sel    (alu_sel),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_carry  (out_carry),
    .out_zero   (out_zero),
    .out_neg    (out_neg),
    .out_sel    (out_sel),
`ifdef ALU_RESULT_PARITY_EN
    .out_parity (out_parity),
`endif
    .count      (count),
    .full       (full),
    .empty      (empty),
    .drop_count (drop_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] res;
    logic       c;
    logic [3:0] sel;
  } exp_t;

  exp_t sb_q[$];
  int   mcount;
  int   mdrop;
  int   n_checks;
  int   n_pass;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
  endtask

  // Monitor: every accepted head entry is compared against the oldest expected result
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        chk("pop_with_empty_scoreboard", 1, 0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("head_result", int'(out_result), int'(e.res));
        chk("head_carry", int'(out_carry), int'(e.c));
        chk("head_sel", int'(out_sel), int'(e.sel));
        chk("head_zero", int'(out_zero), (e.res == 0) ? 1 : 0);
        chk("head_neg", int'(out_neg), (e.res >= 128) ? 1 : 0);
`ifdef ALU_RESULT_PARITY_EN
        chk("head_parity", int'(out_parity), $countones(e.res) % 2);
`endif
      end
    end
  end

  // One clock of stimulus; control outputs are checked against the model before the edge
  task automatic step(input bit v, input logic [7:0] d, input bit c, input logic [3:0] s, input bit r);
    bit do_push;
    bit do_pop;
    in_valid  = v;
    alu_out   = d;
    carry_out = c;
    alu_sel   = s;
    out_ready = r;
    @(negedge clk);
    chk("count", int'(count), mcount);
    chk("in_ready", int'(in_ready), (mcount < DEPTH) ? 1 : 0);
    chk("out_valid", int'(out_valid), (mcount > 0) ? 1 : 0);
    chk("drop_count", int'(drop_count), mdrop);
    if (mcount == 0) chk("empty_result_zero", int'(out_result), 0);
    do_push = v && (mcount < DEPTH);
    do_pop  = r && (mcount > 0);
    if (v && mcount == DEPTH && mdrop < 255) mdrop++;
    if (do_push) begin
      exp_t e;
      e.res = d;
      e.c   = c;
      e.sel = s;
      sb_q.push_back(e);
    end
    mcount = mcount + int'(do_push) - int'(do_pop);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 1; i++) step(1'b0, 8'h00, 1'b0, 4'h0, 1'b1);
  endtask

  initial begin
    n_checks  = 0;
    n_pass    = 0;
    mcount    = 0;
    mdrop     = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    alu_out   = 8'h00;
    carry_out = 1'b0;
    alu_sel   = 4'h0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_empty", int'(empty), 1);
    chk("reset_full", int'(full), 0);
    chk("reset_in_ready", int'(in_ready), 1);
    rst = 1'b0;

    // Single capture
    step(1'b1, 8'h0C, 1'b0, 4'h1, 1'b0);
    chk("single_valid", int'(out_valid), 1);
    chk("single_result", int'(out_result), 12);
    chk("single_zero", int'(out_zero), 0);
    chk("single_neg", int'(out_neg), 0);
    chk("single_sel", int'(out_sel), 1);
    step(1'b0, 8'h00, 1'b0, 4'h0, 1'b1);
    chk("single_popped_empty", int'(empty), 1);

    // Flags
    step(1'b1, 8'h00, 1'b1, 4'h2, 1'b0);
    chk("flag_zero", int'(out_zero), 1);
    chk("flag_carry", int'(out_carry), 1);
    step(1'b0, 8'h00, 1'b0, 4'h0, 1'b1);
    step(1'b1, 8'hF6, 1'b0, 4'h3, 1'b0);
    chk("flag_neg", int'(out_neg), 1);
    chk("flag_not_zero", int'(out_zero), 0);
    step(1'b0, 8'h00, 1'b0, 4'h0, 1'b1);

    // Fill, overflow, drain in order
    for (int i = 1; i <= 4; i++) step(1'b1, 8'(i), 1'b0, 4'h4, 1'b0);
    chk("fill_full", int'(full), 1);
    chk("fill_in_ready", int'(in_ready), 0);
    for (int i = 0; i < 3; i++) step(1'b1, 8'h05, 1'b0, 4'h4, 1'b0);
    chk("overflow_drops", int'(drop_count), 3);
    chk("overflow_head_intact", int'(out_result), 1);
    drain();

    // Concurrent push/pop with two entries held
    step(1'b1, 8'h10, 1'b0, 4'h5, 1'b0);
    step(1'b1, 8'h11, 1'b1, 4'h6, 1'b0);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 8'($urandom_range(0, 255)), 1'($urandom), 4'($urandom), 1'b1);
      chk("concurrent_count", int'(count), 2);
    end
    drain();

    // Saturation of the drop counter
    for (int i = 0; i < 4; i++) step(1'b1, 8'(8'hA0 + i), 1'b0, 4'h7, 1'b0);
    for (int i = 0; i < 300; i++) step(1'b1, 8'hEE, 1'b1, 4'h8, 1'b0);
    chk("drop_saturated", int'(drop_count), 255);
    drain();

`ifdef ALU_RESULT_PARITY_EN
    step(1'b1, 8'h07, 1'b0, 4'h9, 1'b0);
    chk("parity_odd", int'(out_parity), 1);
    step(1'b0, 8'h00, 1'b0, 4'h0, 1'b1);
    step(1'b1, 8'h03, 1'b0, 4'h9, 1'b0);
    chk("parity_even", int'(out_parity), 0);
    step(1'b0, 8'h00, 1'b0, 4'h0, 1'b1);
`endif

    // Asynchronous reset with two entries held
    step(1'b1, 8'h21, 1'b0, 4'hA, 1'b0);
    step(1'b1, 8'h22, 1'b0, 4'hB, 1'b0);
    chk("pre_reset_count", int'(count), 2);
    #2;
    rst = 1'b1;
    #1;
    chk("async_reset_count", int'(count), 0);
    chk("async_reset_empty", int'(empty), 1);
    chk("async_reset_out_valid", int'(out_valid), 0);
    chk("async_reset_result", int'(out_result), 0);
    chk("async_reset_drop", int'(drop_count), 0);
    sb_q.delete();
    mcount = 0;
    mdrop  = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Randomized traffic
    for (int i = 0; i < 500; i++) begin
      step(1'($urandom_range(0, 99) < 60), 8'($urandom), 1'($urandom), 4'($urandom),
           1'($urandom_range(0, 99) < 50));
    end
    drain();
    chk("scoreboard_drained", sb_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
